// File: rtl/echo_emulator.sv
// Ultrasonic target emulator: answers each trigger with an echo pulse after a
// round-trip delay of 2 clk_34 cycles per programmed cm, or a miss if out of range.
module echo_emulator #(
   parameter int CNT_W     = 12,
   parameter int MAX_CM    = 400,
   parameter int ECHO_LEN  = 4,
   parameter int HOLDOFF   = 8,
   parameter int MISS_WAIT = 1024
) (
   input  logic             clk_34,
   input  logic             reset,
   input  logic             enable,
   input  logic             stimulus_in,
   input  logic [CNT_W-1:0] distance_cm,
   output logic             echo_out,
   output logic             busy,
   output logic             miss,
   output logic [7:0]       echo_count
);

   typedef enum logic [2:0] {IDLE, DELAY, ECHO, HOLD, MISS} state_t;

   localparam logic [CNT_W-1:0] MAX_D     = CNT_W'(MAX_CM);
   localparam logic [CNT_W:0]   ZERO      = '0;
   localparam logic [CNT_W:0]   ONE       = (CNT_W+1)'(1);
   localparam logic [CNT_W:0]   TWO       = (CNT_W+1)'(2);
   localparam logic [CNT_W:0]   ECHO_LOAD = (CNT_W+1)'(ECHO_LEN - 1);
   localparam logic [CNT_W:0]   HOLD_LOAD = (CNT_W+1)'(HOLDOFF - 1);
   localparam logic [CNT_W:0]   MISS_LOAD = (CNT_W+1)'(MISS_WAIT - 1);
   localparam logic             MULTI_ECHO = (ECHO_LEN > 1);

   state_t           state;
   logic [CNT_W:0]   cnt;
   logic             s1, s2, s3;
   logic             trig;
   logic [CNT_W:0]   delay_load;

   assign trig       = s2 & ~s3;
   assign delay_load = {distance_cm, 1'b0};

   always_ff @(posedge clk_34 or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= stimulus_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // echo_out runs one cycle ahead of the state: it rises during the last
   // DELAY cycle and falls during the last ECHO cycle, so the pulse starts
   // 2*D+1 cycles after trig while DELAY still spans 2*D+1 cycles.
   always_ff @(posedge clk_34 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= ZERO;
         echo_out   <= 1'b0;
         busy       <= 1'b0;
         miss       <= 1'b0;
         echo_count <= 8'd0;
      end else begin
         miss <= 1'b0;
         if (!enable) begin
            state    <= IDLE;
            cnt      <= ZERO;
            echo_out <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (trig) begin
                     busy <= 1'b1;
                     if (distance_cm > MAX_D) begin
                        state <= MISS;
                        miss  <= 1'b1;
                        cnt   <= MISS_LOAD;
                     end else begin
                        state <= DELAY;
                        cnt   <= delay_load;
                        if (distance_cm == '0) begin
                           echo_out   <= 1'b1;
                           echo_count <= echo_count + 8'd1;
                        end
                     end
                  end
               end
               DELAY: begin
                  if (cnt == ZERO) begin
                     state    <= ECHO;
                     cnt      <= ECHO_LOAD;
                     echo_out <= MULTI_ECHO;
                  end else begin
                     cnt <= cnt - ONE;
                     if (cnt == ONE) begin
                        echo_out   <= 1'b1;
                        echo_count <= echo_count + 8'd1;
                     end
                  end
               end
               ECHO: begin
                  echo_out <= (cnt >= TWO);
                  if (cnt == ZERO) begin
                     state <= HOLD;
                     cnt   <= HOLD_LOAD;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               HOLD: begin
                  if (cnt == ZERO) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               MISS: begin
                  if (cnt == ZERO) begin
                     state <= HOLD;
                     cnt   <= HOLD_LOAD;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  echo_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
